// File: rtl/puf_challenge_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// puf_challenge_sequencer_if : host/datapath signal bundle for the RO-PUF sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
interface puf_challenge_sequencer_if #(
  parameter int NUM_BITS = 16
);
  logic                start;
  logic [3:0]          stride;
  logic [3:0]          base;
  logic [11:0]         cnt1;
  logic [11:0]         cnt2;
  logic [3:0]          select1;
  logic [3:0]          select2;
  logic                ro_enable;
  logic                cnt_reset;
  logic                cnt_enable;
  logic                busy;
  logic                done;
  logic                overflow;
  logic [NUM_BITS-1:0] response;

  modport master (
    output start, stride, base, cnt1, cnt2,
    input  select1, select2, ro_enable, cnt_reset, cnt_enable,
    input  busy, done, overflow, response
  );

  modport slave (
    input  start, stride, base, cnt1, cnt2,
    output select1, select2, ro_enable, cnt_reset, cnt_enable,
    output busy, done, overflow, response
  );
endinterface
`default_nettype wire

// File: rtl/puf_challenge_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// puf_challenge_sequencer : walks RO pairs, gates the edge counters, builds the response
// Optional PUF_SEQ_MAJORITY_EN: 3 measurements per pair, majority vote. Rev 1.0
// ----------------------------------------------------------------------------
module puf_challenge_sequencer #(
  parameter int NUM_BITS = 16,
  parameter int WINDOW   = 4095,
  parameter int SETTLE   = 8,
  parameter int HOLD     = 4
) (
  input  wire logic                clock,
  input  wire logic                reset,
  puf_challenge_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_COUNT  = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_SAMPLE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam int T_A   = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int T_MAX = (T_A > HOLD) ? T_A : HOLD;
  localparam int TW    = $clog2(T_MAX + 1);
  localparam int KW    = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE - 1);
  localparam logic [TW-1:0] WINDOW_LAST = TW'(WINDOW - 1);
  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD - 1);
  localparam logic [KW-1:0] K_LAST      = KW'(NUM_BITS - 1);

  logic [2:0]          state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [KW-1:0]       k_q, k_d;
  logic [3:0]          base_q, base_d;
  logic [3:0]          stride_q, stride_d;
  logic [NUM_BITS-1:0] response_q, response_d;
  logic                overflow_q, overflow_d;
  logic [3:0]          select1_q, select1_d;
  logic [3:0]          select2_q, select2_d;
  logic                ro_enable_q, ro_enable_d;
  logic                cnt_reset_q, cnt_reset_d;
  logic                cnt_enable_q, cnt_enable_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef PUF_SEQ_MAJORITY_EN
  logic [1:0]          rep_q, rep_d;
  logic [1:0]          votes_q, votes_d;
`endif

  logic cmp_bit;
  logic cmp_ovf;

  assign cmp_bit = (bus.cnt1 > bus.cnt2);
  assign cmp_ovf = (bus.cnt1 == 12'hFFF) || (bus.cnt2 == 12'hFFF);

  // State register: every output is a flop loaded from the output comb below.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      k_q          <= '0;
      base_q       <= '0;
      stride_q     <= 4'd1;
      response_q   <= '0;
      overflow_q   <= 1'b0;
      select1_q    <= '0;
      select2_q    <= '0;
      ro_enable_q  <= 1'b0;
      cnt_reset_q  <= 1'b0;
      cnt_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef PUF_SEQ_MAJORITY_EN
      rep_q        <= '0;
      votes_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      k_q          <= k_d;
      base_q       <= base_d;
      stride_q     <= stride_d;
      response_q   <= response_d;
      overflow_q   <= overflow_d;
      select1_q    <= select1_d;
      select2_q    <= select2_d;
      ro_enable_q  <= ro_enable_d;
      cnt_reset_q  <= cnt_reset_d;
      cnt_enable_q <= cnt_enable_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef PUF_SEQ_MAJORITY_EN
      rep_q        <= rep_d;
      votes_q      <= votes_d;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    k_d        = k_q;
    base_d     = base_q;
    stride_d   = stride_q;
    response_d = response_q;
    overflow_d = overflow_q;
`ifdef PUF_SEQ_MAJORITY_EN
    rep_d      = rep_q;
    votes_d    = votes_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_SETUP;
          timer_d    = '0;
          k_d        = '0;
          base_d     = bus.base;
          stride_d   = (bus.stride == 4'd0) ? 4'd1 : bus.stride;
          response_d = '0;
          overflow_d = 1'b0;
`ifdef PUF_SEQ_MAJORITY_EN
          rep_d      = '0;
          votes_d    = '0;
`endif
        end
      end
      S_SETUP: begin
        if (timer_q == SETTLE_LAST) begin
          state_d = S_COUNT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_COUNT: begin
        if (timer_q == WINDOW_LAST) begin
          state_d = S_HOLD;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (timer_q == HOLD_LAST) begin
          state_d = S_SAMPLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        overflow_d = overflow_q | cmp_ovf;
        state_d    = S_SETUP;
        timer_d    = '0;
`ifdef PUF_SEQ_MAJORITY_EN
        if (rep_q != 2'd2) begin
          rep_d   = rep_q + 2'd1;
          votes_d = votes_q + {1'b0, cmp_bit};
        end else begin
          rep_d   = '0;
          votes_d = '0;
          // Two of three already won, or one plus this final result.
          response_d[k_q] = (votes_q == 2'd2) || ((votes_q == 2'd1) && cmp_bit);
          if (k_q == K_LAST) begin
            state_d = S_DONE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
`else
        response_d[k_q] = cmp_bit;
        if (k_q == K_LAST) begin
          state_d = S_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so they line up with it once registered.
  always_comb begin
    select1_d = select1_q;
    select2_d = select2_q;
    if ((state_d == S_SETUP) && (state_q != S_SETUP)) begin
      select1_d = base_d + 4'(k_d);
      select2_d = select1_d + stride_d;
    end
    ro_enable_d  = (state_d == S_SETUP) || (state_d == S_COUNT) ||
                   (state_d == S_HOLD)  || (state_d == S_SAMPLE);
    cnt_reset_d  = (state_d == S_SETUP) && (state_q != S_SETUP);
    cnt_enable_d = (state_d == S_COUNT);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  assign bus.select1    = select1_q;
  assign bus.select2    = select2_q;
  assign bus.ro_enable  = ro_enable_q;
  assign bus.cnt_reset  = cnt_reset_q;
  assign bus.cnt_enable = cnt_enable_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.overflow   = overflow_q;
  assign bus.response   = response_q;

endmodule
`default_nettype wire
